// File: rtl/booth_mul_ctrl_pkg.sv
// Shared constants for the radix-2 Booth multiplier sequencer.
package booth_mul_ctrl_pkg;

    localparam int MUL_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/add_sub.sv
// Shared 8-bit adder/subtractor: s = a + b (oper=0) or a - b (oper=1), combinational.
module add_sub
    import booth_mul_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic [MUL_W-1:0] a,
    input  logic [MUL_W-1:0] b,
    input  logic             oper,
    output logic [MUL_W-1:0] s
);

    // The clock pin exists for drop-in compatibility with registered variants.
    logic unused_clk;
    assign unused_clk = clk;

    // Add or subtract selected by oper; wraps modulo 2^MUL_W.
    always_comb begin
        s = (oper == OP_SUB) ? (a - b) : (a + b);
    end

endmodule

// File: rtl/booth_mul_ctrl.sv
// Radix-2 Booth sequencer: 8x8 signed multiply over one shared add_sub unit,
// one add/sub/pass step plus arithmetic right shift per clock.
module booth_mul_ctrl
    import booth_mul_ctrl_pkg::*;
#(
    parameter int WIDTH = MUL_W,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    state_t           state;
    logic [WIDTH-1:0] a_q, q_q, m_q;
    logic             q_1;
    logic [CNT_W-1:0] count;

    logic             oper;
    logic [WIDTH-1:0] sum, s;
    logic             ovf, tsign;
    logic [WIDTH-1:0] a_nxt, q_nxt;

    add_sub u_add_sub (
        .clk  (clk),
        .a    (a_q),
        .b    (m_q),
        .oper (oper),
        .s    (sum)
    );

    // Booth decode plus overflow correction so that the shifted-in sign is the
    // true 9-bit sign (needed when M = -128 makes A-M leave the 8-bit range).
    always_comb begin
        oper = OP_ADD;
        s    = a_q;
        ovf  = 1'b0;
        case ({q_q[0], q_1})
            2'b10: begin
                oper = OP_SUB;
                s    = sum;
                ovf  = (a_q[WIDTH-1] != m_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            2'b01: begin
                oper = OP_ADD;
                s    = sum;
                ovf  = (a_q[WIDTH-1] == m_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            default: ;
        endcase
        tsign = s[WIDTH-1] ^ ovf;
        a_nxt = {tsign, s[WIDTH-1:1]};
        q_nxt = {s[0], q_q[WIDTH-1:1]};
    end

    // Sequencer FSM with registered busy/done/product.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            q_1     <= 1'b0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        m_q   <= multiplicand;
                        q_q   <= multiplier;
                        a_q   <= '0;
                        q_1   <= 1'b0;
                        count <= CNT_W'(WIDTH);
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_q   <= a_nxt;
                    q_q   <= q_nxt;
                    q_1   <= q_q[0];
                    count <= count - 1'b1;
                    if (count == CNT_W'(1)) begin
                        product <= {a_nxt, q_nxt};
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Directed bench for booth_mul_ctrl: hand-computed products, latency and protocol.
module tb_booth_mul_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  multiplicand, multiplier;
    logic        busy, done;
    logic [15:0] product;

    int n_cmp = 0;
    int n_bad = 0;

    booth_mul_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One operation from IDLE; optional stray start with other operands mid-RUN.
    task automatic do_op(input string tag, input logic [7:0] m, input logic [7:0] q,
                         input logic [15:0] exp, input bit glitch);
        int bcnt = 0;
        int dcnt = 0;
        @(negedge clk);
        start = 1'b1; multiplicand = m; multiplier = q;
        @(negedge clk);
        start = 1'b0; multiplicand = 8'h55; multiplier = 8'hAA;
        for (int i = 0; i < 8; i++) begin
            if (busy) bcnt++;
            if (done) dcnt++;
            if (glitch && i == 2) begin
                start = 1'b1; multiplicand = 8'h09; multiplier = 8'h09;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk({tag, " busy_cycles"}, bcnt, 8);
        chk({tag, " early_done"}, dcnt, 0);
        chk({tag, " done"}, done, 1);
        chk({tag, " product"}, product, exp);
        @(negedge clk);
        chk({tag, " done_pulse"}, done, 0);
        chk({tag, " product_held"}, product, exp);
    endtask

    initial begin
        int first_busy, second_busy, dpulses, dcnt;
        logic busy_d;
        reset = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
        repeat (3) @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst product", product, 0);
        reset = 1'b0;

        do_op("3x5",       8'd3,  8'd5,  16'h000F, 1'b0);
        do_op("-3x5",      8'hFD, 8'd5,  16'hFFF1, 1'b0);
        do_op("5x-3",      8'd5,  8'hFD, 16'hFFF1, 1'b0);
        do_op("-128x-128", 8'h80, 8'h80, 16'h4000, 1'b0);
        do_op("127x-128",  8'h7F, 8'h80, 16'hC080, 1'b0);
        do_op("-128x127",  8'h80, 8'h7F, 16'hC080, 1'b0);
        do_op("0x-128",    8'h00, 8'h80, 16'h0000, 1'b0);
        do_op("-1x1",      8'hFF, 8'h01, 16'hFFFF, 1'b0);
        do_op("7x-2 glitch", 8'd7, 8'hFE, 16'hFFF2, 1'b1);

        // start held high: accepts every 10 cycles
        @(negedge clk);
        start = 1'b1; multiplicand = 8'd2; multiplier = 8'd3;
        first_busy = -1; second_busy = -1; dpulses = 0; busy_d = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy && !busy_d) begin
                if (first_busy < 0) first_busy = c;
                else if (second_busy < 0) second_busy = c;
            end
            if (done) dpulses++;
            busy_d = busy;
        end
        start = 1'b0;
        chk("hold accept_gap", second_busy - first_busy, 10);
        chk("hold done_count", dpulses, 4);
        chk("hold product", product, 16'h0006);
        repeat (12) @(negedge clk);

        // reset during step 4
        @(negedge clk);
        start = 1'b1; multiplicand = 8'd3; multiplier = 8'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst product", product, 0);
        dcnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("midrst no_done", dcnt, 0);
        chk("midrst product_after", product, 0);
        do_op("6x7", 8'd6, 8'd7, 16'h002A, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/booth_mul_ctrl.md
Name: booth_mul_ctrl

Overview:
- Sequencer for 8x8 signed (two's complement) multiplication using radix-2 Booth's algorithm.
- Time-multiplexes one 8-bit add_sub unit over WIDTH iterations. Each iteration selects add, subtract or pass, then performs an arithmetic right shift of the partial product.
- Sits between the control path (start/done handshake) and the shared 8-bit adder/subtractor; produces a 16-bit signed product.

Parameters:
- WIDTH, 8, operand width; fixed to the add_sub datapath width; other values unsupported.
- CNT_W, 4, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high; clears all state
- start  input  1  request; sampled only in IDLE
- multiplicand  input  8  signed operand M, captured on accepted start
- multiplier  input  8  signed operand Q, captured on accepted start
- busy  output  1  high while iterating (RUN)
- done  output  1  one-cycle pulse, product valid
- product  output  16  signed result {A,Q}; held until next accepted start

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high: while reset=1 at a rising edge, the state goes to IDLE, A, Q, M, Q_1, count and product are cleared to 0, and busy=done=0.
- Reset mid-RUN aborts the operation. No done pulse is issued and product reads 0.
- Registers: A[7:0] accumulator, Q[7:0], Q_1 (1 bit), M[7:0], count[CNT_W-1:0], state.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 loads M=multiplicand, Q=multiplier, A=0, Q_1=0, count=WIDTH, then goes to RUN.
  - start=0 stays in IDLE.
- RUN, one Booth step per clock:
  - {Q[0],Q_1}=10: add_sub oper=1, S=A-M.
  - {Q[0],Q_1}=01: oper=0, S=A+M.
  - {Q[0],Q_1}=00 or 11: S=A. The adder output is ignored and oper is driven 0.
  - Overflow: ovf=1 when the add/sub result sign differs from the true 9-bit sign. For add: A[7]==M[7] && S[7]!=A[7]. For sub: A[7]!=M[7] && S[7]!=A[7]. For pass: ovf=0.
  - True sign: tsign = S[7]^ovf.
  - Shift: A <= {tsign, S[7:1]}; Q <= {S[0], Q[7:1]}; Q_1 <= Q[0]; count <= count-1.
  - When count==1 at the step edge: go to DONE and load product <= the post-shift {A,Q}.
- DONE: done=1 for exactly one cycle, then unconditional return to IDLE. start in DONE is ignored.
- Latency: start sampled at edge N → steps at edges N+1..N+8 → done=1 in the cycle after edge N+8.
  - busy=1 in the cycles after edges N..N+7.
  - Next start is accepted at edge N+10 at the earliest.
- Start while busy or in DONE is ignored. Operand inputs are don't-care outside the accepting edge.
- Full signed range is supported, including M=-128 (handled by the ovf correction). Products are exact; the 16-bit product never overflows.
- add_sub inputs are driven combinationally from registers: a=A, b=M, oper as above. The sum is consumed in the same cycle. The add_sub clk input is tied to clk.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - OP_ADD=1'b0, OP_SUB=1'b1;
  - MUL_W=8.
- One sub-module instance: the existing add_sub 8-bit adder/subtractor as the shared datapath.
- Booth decode, overflow/sign correction and shift register stay in booth_mul_ctrl.

Test Plan:
- Basic positive: M=3, Q=5, start pulse → done after 9 cycles, product=16'h000F, busy high for 8 cycles.
- Mixed sign: M=-3 (8'hFD), Q=5 → product=16'hFFF1; then M=5, Q=-3 → 16'hFFF1.
- Extreme values:
  - M=-128, Q=-128 → 16'h4000.
  - M=127, Q=-128 → 16'hC080.
  - M=-128, Q=127 → 16'hC080.
- Zero/identity: M=0, Q=8'h80 → 16'h0000; M=8'hFF, Q=1 → 16'hFFFF.
- Protocol:
  - start held high continuously → operations accepted only every 10 cycles.
  - start pulsed at cycle 3 of RUN → ignored; result matches the first operands.
  - done is a single-cycle pulse; product stays stable until the next accepted start.
- Reset mid-run: assert reset at step 4 → next cycle state IDLE, busy=0, done never pulses, product=0; a new start then completes 6*7=16'h002A normally.
